// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_bht
//  Description : Table of saturating counters indexed by PC (bimodal) or by
//                PC xor global history (gshare). Combinational lookup,
//                resolution-time update, non-speculative history, and
//                branch / mispredict statistics for CSR readout.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_bht #(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 6,
  parameter int MODE    = 0,
  parameter int PC_LSB  = 2,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid_i,
  input  logic [31:0]      pred_pc_i,
  output logic             pred_taken_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  input  logic             upd_mispredict_i,
  input  logic             clr_stats_i,
  output logic [GHR_W-1:0] ghr_o,
  output logic [31:0]      branch_cnt_o,
  output logic [31:0]      mispredict_cnt_o
);

  // Weakly not-taken start value and saturation ceiling
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic [CTR_W-1:0] upd_ctr_cur;
  logic [CTR_W-1:0] upd_ctr_d;
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_shift;
  logic [GHR_W-1:0] ghr_d;
  logic [31:0]      branch_cnt_q;
  logic [31:0]      branch_cnt_d;
  logic [31:0]      mispredict_cnt_q;
  logic [31:0]      mispredict_cnt_d;
  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] lookup_idx;

  // The query valid only qualifies the pipeline's own bookkeeping; the
  // lookup itself is always live and only part of the PC feeds the index.
  logic unused_pred_inputs;
  assign unused_pred_inputs = ^{pred_valid_i, pred_pc_i};

  assign pc_idx = pred_pc_i[PC_LSB +: IDX_W];

  generate
    if (MODE == 1) begin : g_gshare
      logic [IDX_W-1:0] hist;
      if (GHR_W < IDX_W) begin : g_hist_ext
        assign hist = {{(IDX_W - GHR_W){1'b0}}, ghr_q};
      end else begin : g_hist_trunc
        assign hist = ghr_q[IDX_W-1:0];
      end
      assign lookup_idx = pc_idx ^ hist;
    end else begin : g_bimodal
      assign lookup_idx = pc_idx;
    end
  endgenerate

  // Read-before-write: the query always sees the current (pre-update) table
  assign pred_idx_o   = lookup_idx;
  assign pred_taken_o = ctr_q[lookup_idx][CTR_W-1];

  // Saturating increment / decrement of the entry being resolved
  assign upd_ctr_cur = ctr_q[upd_idx_i];
  always_comb begin
    upd_ctr_d = upd_ctr_cur;
    if (upd_taken_i) begin
      if (upd_ctr_cur != CTR_MAX) upd_ctr_d = upd_ctr_cur + CTR_W'(1);
    end else begin
      if (upd_ctr_cur != '0) upd_ctr_d = upd_ctr_cur - CTR_W'(1);
    end
  end

  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign ghr_shift = upd_taken_i;
    end else begin : g_ghr_shift
      assign ghr_shift = {ghr_q[GHR_W-2:0], upd_taken_i};
    end
  endgenerate

  // History and statistics next-state; clear wins over an increment
  always_comb begin
    ghr_d            = upd_valid_i ? ghr_shift : ghr_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (clr_stats_i) begin
      branch_cnt_d     = '0;
      mispredict_cnt_d = '0;
    end else if (upd_valid_i) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (upd_mispredict_i) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  // Counter table: reset to weakly not-taken, one entry written per resolution
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
    end else if (upd_valid_i) begin
      ctr_q[upd_idx_i] <= upd_ctr_d;
    end
  end

  // Global history and statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q            <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      ghr_q            <= ghr_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign ghr_o            = ghr_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_bht
//  Description : Self-checking bench; a bimodal and a gshare instance share
//                all inputs and are compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_bht;

  localparam int IDX_W = 6;
  localparam int GHR_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pred_valid_i = 1'b0;
  logic [31:0]      pred_pc_i = '0;
  logic             upd_valid_i = 1'b0;
  logic [IDX_W-1:0] upd_idx_i = '0;
  logic             upd_taken_i = 1'b0;
  logic             upd_mispredict_i = 1'b0;
  logic             clr_stats_i = 1'b0;

  logic             taken_b, taken_g;
  logic [IDX_W-1:0] idx_b, idx_g;
  logic [GHR_W-1:0] ghr_b, ghr_g;
  logic [31:0]      br_b, br_g, mp_b, mp_g;

  always #5 clk = ~clk;

  branch_predictor_bht #(.MODE(0)) u_bim (
    .clk(clk), .rst(rst), .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
    .pred_taken_o(taken_b), .pred_idx_o(idx_b), .upd_valid_i(upd_valid_i),
    .upd_idx_i(upd_idx_i), .upd_taken_i(upd_taken_i),
    .upd_mispredict_i(upd_mispredict_i), .clr_stats_i(clr_stats_i),
    .ghr_o(ghr_b), .branch_cnt_o(br_b), .mispredict_cnt_o(mp_b));

  branch_predictor_bht #(.MODE(1)) u_gsh (
    .clk(clk), .rst(rst), .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
    .pred_taken_o(taken_g), .pred_idx_o(idx_g), .upd_valid_i(upd_valid_i),
    .upd_idx_i(upd_idx_i), .upd_taken_i(upd_taken_i),
    .upd_mispredict_i(upd_mispredict_i), .clr_stats_i(clr_stats_i),
    .ghr_o(ghr_g), .branch_cnt_o(br_g), .mispredict_cnt_o(mp_g));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: plain integers, counters in 0..3, history as a number
  int          m_tbl [64];
  int          m_ghr;
  logic [31:0] m_br, m_mp;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tbl[i] = 1;
    m_ghr = 0;
    m_br  = 0;
    m_mp  = 0;
  endtask

  function automatic int model_idx(input logic [31:0] pc, input int mode);
    int base;
    base = int'((pc / 4) % 64);
    return (mode == 1) ? (base ^ m_ghr) : base;
  endfunction

  logic        obs_tk_b, obs_tk_g;
  logic [31:0] obs_idx_b, obs_idx_g, obs_ghr, obs_br, obs_mp;

  // One clock: drive at negedge, check combinational view, then advance model
  task automatic do_cycle(input bit pv, input logic [31:0] pc, input bit uv,
                          input int uidx, input bit ut, input bit um, input bit clr);
    int i0, i1;
    @(negedge clk);
    pred_valid_i     = pv;
    pred_pc_i        = pc;
    upd_valid_i      = uv;
    upd_idx_i        = uidx[5:0];
    upd_taken_i      = ut;
    upd_mispredict_i = um;
    clr_stats_i      = clr;
    #2;
    i0 = model_idx(pc, 0);
    i1 = model_idx(pc, 1);
    check_eq("idx_bim",   32'(idx_b),   32'(i0));
    check_eq("taken_bim", 32'(taken_b), 32'(m_tbl[i0] >= 2));
    check_eq("idx_gsh",   32'(idx_g),   32'(i1));
    check_eq("taken_gsh", 32'(taken_g), 32'(m_tbl[i1] >= 2));
    check_eq("ghr_bim",   32'(ghr_b),   32'(m_ghr));
    check_eq("ghr_gsh",   32'(ghr_g),   32'(m_ghr));
    check_eq("brcnt",     br_b,         m_br);
    check_eq("mpcnt",     mp_g,         m_mp);
    obs_tk_b  = taken_b;  obs_tk_g  = taken_g;
    obs_idx_b = 32'(idx_b); obs_idx_g = 32'(idx_g);
    obs_ghr   = 32'(ghr_g); obs_br = br_b; obs_mp = mp_b;
    @(posedge clk);
    if (uv) begin
      if (ut) m_tbl[uidx % 64] = (m_tbl[uidx % 64] == 3) ? 3 : m_tbl[uidx % 64] + 1;
      else    m_tbl[uidx % 64] = (m_tbl[uidx % 64] == 0) ? 0 : m_tbl[uidx % 64] - 1;
      m_ghr = ((m_ghr * 2) + int'(ut)) % 64;
    end
    if (clr) begin
      m_br = 0;
      m_mp = 0;
    end else if (uv) begin
      m_br = m_br + 1;
      if (um) m_mp = m_mp + 1;
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset state seen from several PCs
    do_cycle(1, 32'h0,   0, 0, 0, 0, 0);
    check_eq("rst_pc0", 32'(obs_tk_b), 0);
    do_cycle(1, 32'h100, 0, 0, 0, 0, 0);
    check_eq("rst_pc100", 32'(obs_tk_b), 0);
    do_cycle(1, 32'hFC,  0, 0, 0, 0, 0);
    check_eq("rst_pcfc", 32'(obs_tk_b), 0);
    check_eq("rst_ghr", obs_ghr, 0);
    check_eq("rst_br", obs_br, 0);

    // Saturate up then down on index 5 (pc 0x14)
    for (int k = 0; k < 4; k++) begin
      do_cycle(1, 32'h14, 1, 5, 1, 0, 0);
      if (k == 1) check_eq("sat_up_taken", 32'(obs_tk_b), 1);
    end
    for (int k = 0; k < 4; k++) begin
      do_cycle(1, 32'h14, 1, 5, 0, 0, 0);
      if (k == 2) check_eq("dn_after2", 32'(obs_tk_b), 0);
    end
    do_cycle(1, 32'h14, 0, 0, 0, 0, 0);
    check_eq("sat_dn_hold", 32'(obs_tk_b), 0);

    // Same-cycle query and update: pre-update value, new value next cycle
    do_cycle(0, 32'h0, 1, 5, 1, 0, 0);
    do_cycle(1, 32'h14, 1, 5, 1, 0, 0);
    check_eq("rbw_same", 32'(obs_tk_b), 0);
    do_cycle(1, 32'h14, 0, 0, 0, 0, 0);
    check_eq("rbw_next", 32'(obs_tk_b), 1);

    // History 0,0,0,0,1,1 -> 6'b000011, gshare index 5^3
    for (int k = 0; k < 6; k++) do_cycle(0, 32'h0, 1, 40, (k >= 4), 0, 0);
    do_cycle(1, 32'h14, 0, 0, 0, 0, 0);
    check_eq("hist_ghr", obs_ghr, 32'h3);
    check_eq("hist_idx_gsh", obs_idx_g, 6);
    check_eq("hist_idx_bim", obs_idx_b, 5);

    // Statistics: 8 branches, 3 mispredicts, a stray mispredict flag ignored
    do_cycle(0, 32'h0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) do_cycle(0, 32'h0, 1, 40, k[0], (k < 3), 0);
    do_cycle(0, 32'h0, 0, 0, 0, 1, 0);
    do_cycle(0, 32'h0, 0, 0, 0, 0, 0);
    check_eq("stat_br", obs_br, 8);
    check_eq("stat_mp", obs_mp, 3);
    do_cycle(0, 32'h0, 1, 40, 1, 1, 1);
    do_cycle(0, 32'h0, 0, 0, 0, 0, 0);
    check_eq("clr_br", obs_br, 0);
    check_eq("clr_mp", obs_mp, 0);

    // Drive index 5 to 11 with nonzero history, then reset between edges
    for (int k = 0; k < 3; k++) do_cycle(0, 32'h0, 1, 5, 1, 0, 0);
    @(negedge clk);
    pred_pc_i   = 32'h14;
    upd_valid_i = 1'b1;
    upd_idx_i   = 6'd5;
    upd_taken_i = 1'b1;
    #2;
    check_eq("pre_arst_ghr_nz", 32'(ghr_b != 0), 1);
    rst = 1'b0;
    #1;
    check_eq("arst_taken", 32'(taken_b), 0);
    check_eq("arst_ghr", 32'(ghr_b), 0);
    check_eq("arst_br", br_b, 0);
    check_eq("arst_mp", mp_b, 0);
    model_reset();
    @(negedge clk);
    upd_valid_i = 1'b0;
    #3;
    rst = 1'b1;
    do_cycle(1, 32'h14, 1, 5, 1, 0, 0);
    check_eq("post_arst_pre", 32'(obs_tk_b), 0);
    do_cycle(1, 32'h14, 0, 0, 0, 0, 0);
    check_eq("post_arst_upd", 32'(obs_tk_b), 1);
    check_eq("post_arst_ghr", obs_ghr, 1);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [31:0] pc;
      int          uidx;
      pc = $urandom;
      if ($urandom_range(1, 0) == 1) uidx = model_idx($urandom, int'($urandom_range(1, 0)));
      else                           uidx = int'($urandom_range(63, 0));
      do_cycle(1'($urandom), pc, ($urandom_range(3, 0) != 0), uidx, 1'($urandom),
               1'($urandom), ($urandom_range(19, 0) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
